// File: rtl/book_update_sequencer_if.sv
// Requester handshake bundle: valid/ready with one packed 92-bit book message.
interface book_update_sequencer_if;
    logic        valid;
    logic        ready;
    logic [91:0] msg;

    modport master (output valid, output msg, input ready);
    modport slave  (input valid, input msg, output ready);
endinterface

// File: rtl/book_update_sequencer.sv
// Two requester FIFOs arbitrated into a registered one-cycle order-book strobe.
// Define BOOK_SEQ_B_PRIORITY_EN for strict B priority; default build is round-robin.
module book_update_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    book_update_sequencer_if.slave a,
    book_update_sequencer_if.slave b,
    input  logic                   freeze,
    output logic                   message_ready,
    output logic                   enable_order_book,
    output logic [7:0]             NUM_ORDERS,
    output logic [15:0]            QUANTITY,
    output logic [63:0]            PRICE,
    output logic [1:0]             ACTION,
    output logic [1:0]             ENTRY_TYPE,
    output logic [15:0]            issue_count,
    output logic [7:0]             drop_count
);
    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_t;
    state_t r_state, w_state_next;

    // Index 0 is requester A, index 1 is requester B.
    logic [91:0]   r_mem [2][FIFO_DEPTH];
    logic [AW-1:0] r_wr  [2];
    logic [AW-1:0] r_rd  [2];
    logic [AW:0]   r_cnt [2];
    logic [91:0]   w_msg_in [2];
    logic [1:0]    w_valid, w_ready, w_push, w_pop, w_nonempty;
    logic [91:0]   w_pop_msg;
    logic          w_malformed;

    logic          r_mr, r_enable;
    logic [91:0]   r_fields;
    logic [15:0]   r_issue;
    logic [7:0]    r_drop;

    assign w_valid     = {b.valid, a.valid};
    assign w_msg_in[0] = a.msg;
    assign w_msg_in[1] = b.msg;
    assign a.ready     = w_ready[0];
    assign b.ready     = w_ready[1];

    always_comb begin
        w_ready    = '0;
        w_nonempty = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            w_ready[i]    = (r_cnt[i] != FULL_CNT);
            w_nonempty[i] = (r_cnt[i] != '0);
        end
    end

    // Ready depends only on occupancy, so a full FIFO never accepts even while popping.
    assign w_push = w_valid & w_ready;

`ifdef BOOK_SEQ_B_PRIORITY_EN
    always_comb begin
        w_pop = '0;
        if (r_state == RUN) begin
            if (w_nonempty[1])      w_pop[1] = 1'b1;
            else if (w_nonempty[0]) w_pop[0] = 1'b1;
        end
    end
`else
    logic r_rr_ptr;

    always_comb begin
        w_pop = '0;
        if (r_state == RUN) begin
            if (w_nonempty[r_rr_ptr])       w_pop[r_rr_ptr]  = 1'b1;
            else if (w_nonempty[~r_rr_ptr]) w_pop[~r_rr_ptr] = 1'b1;
        end
    end

    // Pointer only advances when the favoured requester was the one served.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              r_rr_ptr <= 1'b0;
        else if (w_pop[r_rr_ptr])  r_rr_ptr <= ~r_rr_ptr;
    end
`endif

    assign w_pop_msg   = w_pop[1] ? r_mem[1][r_rd[1]] : r_mem[0][r_rd[0]];
    assign w_malformed = (w_pop_msg[3:2] == 2'b11) || w_pop_msg[1];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (freeze)  w_state_next = FROZEN;
            FROZEN:  if (!freeze) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= RUN;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (w_push[i]) r_mem[i][r_wr[i]] <= w_msg_in[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_wr[i]  <= '0;
                r_rd[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (w_push[i]) r_wr[i] <= r_wr[i] + 1'b1;
                if (w_pop[i])  r_rd[i] <= r_rd[i] + 1'b1;
                if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
                else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mr     <= 1'b0;
            r_enable <= 1'b0;
            r_fields <= '0;
            r_issue  <= '0;
            r_drop   <= '0;
        end else begin
            r_mr     <= 1'b0;
            r_enable <= (w_state_next == RUN);
            if (|w_pop) begin
                if (w_malformed) begin
                    if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
                end else begin
                    r_mr     <= 1'b1;
                    r_fields <= w_pop_msg;
                    r_issue  <= r_issue + 16'd1;
                end
            end
        end
    end

    assign message_ready     = r_mr;
    assign enable_order_book = r_enable;
    assign {NUM_ORDERS, QUANTITY, PRICE, ACTION, ENTRY_TYPE} = r_fields;
    assign issue_count       = r_issue;
    assign drop_count        = r_drop;
endmodule

// File: tb/tb_book_update_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_book_update_sequencer;
    localparam int DEPTH = 4;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        freeze  = 1'b0;
    logic        message_ready, enable_order_book;
    logic [7:0]  NUM_ORDERS;
    logic [15:0] QUANTITY;
    logic [63:0] PRICE;
    logic [1:0]  ACTION, ENTRY_TYPE;
    logic [15:0] issue_count;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_errors = 0;

    book_update_sequencer_if a_if();
    book_update_sequencer_if b_if();

    book_update_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .a                 (a_if),
        .b                 (b_if),
        .freeze            (freeze),
        .message_ready     (message_ready),
        .enable_order_book (enable_order_book),
        .NUM_ORDERS        (NUM_ORDERS),
        .QUANTITY          (QUANTITY),
        .PRICE             (PRICE),
        .ACTION            (ACTION),
        .ENTRY_TYPE        (ENTRY_TYPE),
        .issue_count       (issue_count),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    // Reference model state: queues per requester plus expected output values.
    logic [91:0] qa[$];
    logic [91:0] qb[$];
    logic [91:0] dut_log[$];
    bit          m_frozen, m_ptr_b, m_mr, m_en;
    logic [91:0] m_fields;
    logic [15:0] m_issue;
    logic [7:0]  m_drop;

    function automatic logic [91:0] mk(input logic [7:0] o, input logic [15:0] q,
                                       input logic [63:0] p, input logic [1:0] ac,
                                       input logic [1:0] et);
        return {o, q, p, ac, et};
    endfunction

    function automatic logic [91:0] rnd_msg();
        logic [91:0] m;
        m[91:60] = $urandom;
        m[59:28] = $urandom;
        m[27:0]  = 28'($urandom);
        if ($urandom_range(0, 7) != 0) begin
            m[3:2] = 2'($urandom_range(0, 2));
            m[1:0] = 2'($urandom_range(0, 1));
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [91:0] got, input logic [91:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_frozen = 1'b0;
        m_ptr_b  = 1'b0;
        m_mr     = 1'b0;
        m_en     = 1'b0;
        m_fields = '0;
        m_issue  = '0;
        m_drop   = '0;
    endtask

    task automatic model_step(input bit va, input logic [91:0] ma,
                              input bit vb, input logic [91:0] mb, input bit frz);
        bit          ra, rb, popped;
        logic [91:0] pm;
        ra     = qa.size() < DEPTH;
        rb     = qb.size() < DEPTH;
        popped = 1'b0;
        pm     = '0;
        if (!m_frozen) begin
`ifdef BOOK_SEQ_B_PRIORITY_EN
            if (qb.size() > 0)      begin pm = qb.pop_front(); popped = 1'b1; end
            else if (qa.size() > 0) begin pm = qa.pop_front(); popped = 1'b1; end
`else
            if (m_ptr_b && qb.size() > 0) begin
                pm = qb.pop_front(); popped = 1'b1; m_ptr_b = 1'b0;
            end else if (!m_ptr_b && qa.size() > 0) begin
                pm = qa.pop_front(); popped = 1'b1; m_ptr_b = 1'b1;
            end else if (qa.size() > 0) begin
                pm = qa.pop_front(); popped = 1'b1;
            end else if (qb.size() > 0) begin
                pm = qb.pop_front(); popped = 1'b1;
            end
`endif
        end
        m_mr = 1'b0;
        if (popped) begin
            if (pm[3:2] == 2'd3 || pm[1:0] >= 2'd2) begin
                if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
            end else begin
                m_mr     = 1'b1;
                m_fields = pm;
                m_issue  = m_issue + 16'd1;
            end
        end
        if (va && ra) qa.push_back(ma);
        if (vb && rb) qb.push_back(mb);
        m_frozen = frz;
        m_en     = !frz;
    endtask

    task automatic check_outputs();
        check("message_ready", 92'(message_ready), 92'(m_mr));
        check("enable_order_book", 92'(enable_order_book), 92'(m_en));
        check("issue_count", 92'(issue_count), 92'(m_issue));
        check("drop_count", 92'(drop_count), 92'(m_drop));
        check("fields", {NUM_ORDERS, QUANTITY, PRICE, ACTION, ENTRY_TYPE}, m_fields);
        if (message_ready === 1'b1)
            dut_log.push_back({NUM_ORDERS, QUANTITY, PRICE, ACTION, ENTRY_TYPE});
    endtask

    // Called at a falling edge: drive, predict, advance one rising edge, compare.
    task automatic cyc(input bit va, input logic [91:0] ma, input bit vb,
                       input logic [91:0] mb, input bit frz, input bit chk_en);
        a_if.valid = va;
        a_if.msg   = ma;
        b_if.valid = vb;
        b_if.msg   = mb;
        freeze     = frz;
        if (chk_en) begin
            check("a_ready", 92'(a_if.ready), 92'(qa.size() < DEPTH));
            check("b_ready", 92'(b_if.ready), 92'(qb.size() < DEPTH));
        end
        model_step(va, ma, vb, mb, frz);
        @(posedge clk);
        @(negedge clk);
        if (chk_en) check_outputs();
    endtask

    task automatic idle(input int n, input bit frz);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, frz, 1'b1);
    endtask

    // Asserts reset mid-cycle, checks the immediate clear, releases at the next falling edge.
    task automatic do_reset();
        reset_n    = 1'b0;
        a_if.valid = 1'b0;
        b_if.valid = 1'b0;
        freeze     = 1'b0;
        #1;
        model_reset();
        check("rst_message_ready", 92'(message_ready), 92'd0);
        check("rst_enable", 92'(enable_order_book), 92'd0);
        check("rst_fields", {NUM_ORDERS, QUANTITY, PRICE, ACTION, ENTRY_TYPE}, 92'd0);
        check("rst_issue_count", 92'(issue_count), 92'd0);
        check("rst_drop_count", 92'(drop_count), 92'd0);
        check("rst_a_ready", 92'(a_if.ready), 92'd1);
        check("rst_b_ready", 92'(b_if.ready), 92'd1);
        @(negedge clk);
        reset_n = 1'b1;
        dut_log.delete();
    endtask

    logic [91:0] ma3[3];
    logic [91:0] mb3[3];
    logic [91:0] exp_order[6];
    logic [91:0] m29[6];
    logic [91:0] g1, g2;
    bit          rfrz;

    initial begin
        a_if.valid = 1'b0; a_if.msg = '0;
        b_if.valid = 1'b0; b_if.msg = '0;
        @(negedge clk);
        do_reset();
        idle(1, 1'b0);
        check("enable_after_release", 92'(enable_order_book), 92'd1);

        // Single push latency.
        cyc(1'b1, mk(8'd1, 16'd5, 64'd12, 2'd0, 2'd0), 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        check("lat_message_ready", 92'(message_ready), 92'd1);
        check("lat_price", 92'(PRICE), 92'd12);
        check("lat_issue_count", 92'(issue_count), 92'd1);

        // Simultaneous pushes from both requesters.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ma3[i] = mk(8'(16 + i), 16'd100, 64'(1000 + i), 2'd0, 2'd1);
            mb3[i] = mk(8'(32 + i), 16'd200, 64'(2000 + i), 2'd1, 2'd0);
        end
`ifdef BOOK_SEQ_B_PRIORITY_EN
        exp_order = '{mb3[0], mb3[1], mb3[2], ma3[0], ma3[1], ma3[2]};
`else
        exp_order = '{ma3[0], mb3[0], ma3[1], mb3[1], ma3[2], mb3[2]};
`endif
        for (int i = 0; i < 3; i++) cyc(1'b1, ma3[i], 1'b1, mb3[i], 1'b0, 1'b1);
        idle(8, 1'b0);
        check("arb_count", 92'(dut_log.size()), 92'd6);
        for (int i = 0; i < 6; i++)
            if (i < dut_log.size()) check($sformatf("arb_order%0d", i), dut_log[i], exp_order[i]);

        // Freeze with FIFO overflow attempts.
        do_reset();
        for (int i = 0; i < 6; i++) m29[i] = mk(8'(i + 1), 16'(i * 3), 64'(500 + i), 2'd2, 2'd0);
        idle(1, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, m29[i], 1'b0, '0, 1'b1, 1'b1);
        a_if.valid = 1'b0;
        check("frz_a_ready", 92'(a_if.ready), 92'd0);
        check("frz_enable", 92'(enable_order_book), 92'd0);
        check("frz_no_strobe", 92'(dut_log.size()), 92'd0);
        idle(1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1, 1'b0);
            check($sformatf("unfrz_strobe%0d", i), 92'(message_ready), 92'd1);
        end
        check("unfrz_a_ready", 92'(a_if.ready), 92'd1);
        check("unfrz_count", 92'(dut_log.size()), 92'd4);
        for (int i = 0; i < 4; i++)
            if (i < dut_log.size()) check($sformatf("unfrz_order%0d", i), dut_log[i], m29[i]);

        // Malformed messages between two good ones.
        do_reset();
        g1 = mk(8'd7, 16'd70, 64'd700, 2'd0, 2'd0);
        g2 = mk(8'd8, 16'd80, 64'd800, 2'd2, 2'd1);
        cyc(1'b1, g1, 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, mk(8'd9, 16'd90, 64'd900, 2'd3, 2'd0), 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, mk(8'd10, 16'd91, 64'd901, 2'd0, 2'd2), 1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, g2, 1'b0, '0, 1'b0, 1'b1);
        idle(4, 1'b0);
        check("bad_strobes", 92'(dut_log.size()), 92'd2);
        check("bad_drop_count", 92'(drop_count), 92'd2);
        check("bad_issue_count", 92'(issue_count), 92'd2);
        if (dut_log.size() == 2) begin
            check("bad_first", dut_log[0], g1);
            check("bad_second", dut_log[1], g2);
        end

        // Reset mid-stream with queued messages.
        for (int i = 0; i < 3; i++) cyc(1'b1, rnd_msg(), 1'b0, '0, 1'b1, 1'b1);
        do_reset();
        idle(5, 1'b0);
        check("rst_no_strobe", 92'(dut_log.size()), 92'd0);

        // Random traffic.
        rfrz = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rfrz = !rfrz;
            cyc(1'($urandom_range(0, 3) != 0), rnd_msg(),
                1'($urandom_range(0, 2) != 0), rnd_msg(), rfrz, 1'b1);
        end
        idle(12, 1'b0);

        // Counter saturation and wrap.
        do_reset();
        for (int i = 0; i < 260; i++)
            cyc(1'b1, mk(8'(i), 16'd1, 64'(i), 2'd3, 2'd0), 1'b0, '0, 1'b0, 1'b0);
        idle(3, 1'b0);
        check("drop_saturate", 92'(drop_count), 92'd255);
        for (int i = 0; i < 65537; i++)
            cyc(1'b1, mk(8'd1, 16'd1, 64'(i), 2'd0, 2'd0), 1'b0, '0, 1'b0, 1'b0);
        idle(3, 1'b0);
        check("issue_wrap", 92'(issue_count), 92'd1);
        check("drop_hold", 92'(drop_count), 92'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
